ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the 32-bit barrel shifter and ALU.
- Consumes the same rs/rt operand pair from the ID/EX register.
- Holds the architectural HI/LO registers. Their values feed the EX result mux (mfhi/mflo) next to the shifter result.
- Drives a busy flag that the hazard unit uses to stall md-class instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; the operation is selected by op
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=reserved (no-op)
- a  in  32  operand 1 (rs)
- b  in  32  operand 2 (rt)
- busy  out  1  operation in progress
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy=0, hi=0, lo=0, state=IDLE, counter=0, pending result cleared.
  - Reset mid-operation abandons the operation. No HI/LO update follows deassertion.
- State machine: IDLE, BUSY.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU (sampled at edge k):
  - Latch the result into pending_hi/pending_lo.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES) minus 1.
  - busy=1 after edge k. Go to BUSY.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter==0 (edge k+N): hi<=pending_hi, lo<=pending_lo, busy<=0, go to IDLE.
  - Net effect: busy is high for exactly N cycles, and new HI/LO are visible in the same cycle busy falls.
- MTHI/MTLO (IDLE only):
  - At edge k, hi<=a (MTHI) or lo<=a (MTLO).
  - busy stays 0. Single-cycle.
- start while BUSY (any op) is ignored.
  - The hazard unit guarantees this never happens; the block must still be safe.
  - The current operation is unaffected.
- Reserved op with start=1 is a no-op: no state change.
- Arithmetic:
  - MULT: {hi,lo} = signed(a)*signed(b), full 64-bit product.
  - MULTU: the same, unsigned.
  - DIV: lo = a/b signed, truncating toward zero. hi = remainder, sign follows the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow case a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- Divide by zero (b==0, DIV or DIVU):
  - The operation still runs DIV_CYCLES with busy=1.
  - HI/LO are left unchanged at completion.
- Operands are latched at start. Changes on a/b/op during BUSY have no effect.
- hi/lo hold their value between updates; they are never driven combinationally from a/b.

Decomposition:
- Shared package holds:
  - the op encoding constants (MD_MULT..MD_MTLO);
  - localparams for the IDLE/BUSY encoding;
  - default cycle counts.
- One natural sub-module: md_core.
  - Combinational.
  - Computes the 64-bit pending {hi,lo} from a, b and op, including the signed-overflow and divide-by-zero rules.
  - Flags div0 so the top holds HI/LO unchanged.
- The top keeps the FSM, counter, and HI/LO registers.

Test Plan:
- Reset check: assert rst_n=0 mid-clock. Required: busy=0, hi=0, lo=0 with no clock edge.
- MULT: a=0xFFFFFFFE (-2), b=3 at edge k.
  - busy=1 for exactly 5 cycles.
  - At edge k+5: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV: a=-7 (0xFFFFFFF9), b=2.
  - After 10 cycles: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU a=7, b=2: lo=3, hi=1.
- Divide by zero: preload via MTHI 0x1234 and MTLO 0x5678, then DIV with b=0.
  - busy high 10 cycles.
  - hi=0x1234, lo=0x5678 unchanged.
  - Overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Boundary and interference:
  - start MULT, then change a/b and pulse start with DIV at cycle 2. Required: ignored, MULT result delivered at cycle 5.
  - Pull rst_n low at cycle 3 of a DIV. Required: hi=lo=0, busy=0, and no later update.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encoding,
// FSM state encoding and default latencies.
package ex_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/ex_muldiv_md_core.sv
// Combinational arithmetic core: produces the 64-bit {hi,lo} result for
// mult/multu/div/divu and flags divide-by-zero.
module ex_muldiv_md_core
  import ex_muldiv_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div0_o
);

  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // with zero remainder instead of relying on tool-specific overflow handling.
  assign sign_a = (op_i == MD_DIV) & a_i[31];
  assign sign_b = (op_i == MD_DIV) & b_i[31];
  assign mag_a  = sign_a ? (~a_i + 32'd1) : a_i;
  assign mag_b  = sign_b ? (~b_i + 32'd1) : b_i;
  assign div_b  = (b_i == 32'd0) ? 32'd1 : mag_b;
  assign quo    = mag_a / div_b;
  assign rem    = mag_a % div_b;
  assign quo_s  = (sign_a ^ sign_b) ? (~quo + 32'd1) : quo;
  assign rem_s  = sign_a ? (~rem + 32'd1) : rem;

  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  always_comb begin
    res_o  = 64'd0;
    div0_o = 1'b0;
    case (op_i)
      MD_MULT:  res_o = prod_s;
      MD_MULTU: res_o = prod_u;
      MD_DIV, MD_DIVU: begin
        res_o  = {rem_s, quo_s};
        div0_o = (b_i == 32'd0);
      end
      default: res_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: owns HI/LO, runs a fixed-latency busy
// window per operation and commits the precomputed result when it ends.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [0:0]  dbg_state
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             div0_q, div0_d;
  logic [63:0]      core_res;
  logic             core_div0;

  ex_muldiv_md_core u_core (
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .res_o  (core_res),
    .div0_o (core_div0)
  );

  // Result is captured at start, so operand changes while busy are irrelevant.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    div0_d    = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              {pend_hi_d, pend_lo_d} = core_res;
              div0_d  = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              state_d = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              {pend_hi_d, pend_lo_d} = core_res;
              div0_d  = core_div0;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = ST_BUSY;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      default: begin
        if (cnt_q == '0) begin
          if (!div0_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      div0_q    <= div0_d;
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, HI/LO results, div-by-zero,
// overflow, start-while-busy and reset-abort.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [0:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int n;

  ex_muldiv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns at the negedge right after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom_range(0, 7));
  endtask

  // Count negedges with busy high, starting from 'already' cycles seen.
  task automatic wait_done(input int already, output int cnt);
    cnt = already;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
    wait_done(0, n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(0, n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);

    issue(MD_DIVU, 32'd7, 32'd2);
    wait_done(0, n);
    chk("divu_cycles", 32'(n), 32'd10);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    issue(MD_MTHI, 32'h1234, 32'd0);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo_kept", lo, 32'd3);
    issue(MD_MTLO, 32'h5678, 32'd0);
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_lo", lo, 32'h5678);

    issue(MD_DIV, 32'd100, 32'd0);
    wait_done(0, n);
    chk("div0_cycles", 32'(n), 32'd10);
    chk("div0_hi", hi, 32'h1234);
    chk("div0_lo", lo, 32'h5678);

    issue(MD_DIVU, 32'd100, 32'd0);
    wait_done(0, n);
    chk("divu0_cycles", 32'(n), 32'd10);
    chk("divu0_hi", hi, 32'h1234);
    chk("divu0_lo", lo, 32'h5678);

    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, n);
    chk("ovf_cycles", 32'(n), 32'd10);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_lo", lo, 32'h80000000);

    issue(3'd6, 32'hAAAA, 32'hBBBB);
    chk("rsvd_busy", 32'(busy), 32'd0);
    chk("rsvd_hi", hi, 32'd0);
    chk("rsvd_lo", lo, 32'h80000000);

    // MULT 5*7 with a DIV start pulse landing on its second busy cycle
    issue(MD_MULT, 32'd5, 32'd7);
    chk("intf_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("intf_busy2", 32'(busy), 32'd1);
    op = MD_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("intf_busy3", 32'(busy), 32'd1);
    wait_done(2, n);
    chk("intf_cycles", 32'(n), 32'd5);
    chk("intf_hi", hi, 32'd0);
    chk("intf_lo", lo, 32'h23);
    @(negedge clk);
    chk("intf_idle_after", 32'(busy), 32'd0);
    chk("intf_lo_hold", lo, 32'h23);

    issue(MD_MTHI, 32'hCAFE, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    chk("rstdiv_state", 32'(dbg_state), 32'(ST_BUSY));
    #2 rst_n = 1'b0;
    #1;
    chk("rstdiv_busy", 32'(busy), 32'd0);
    chk("rstdiv_hi", hi, 32'd0);
    chk("rstdiv_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("rstdiv_busy_late", 32'(busy), 32'd0);
    chk("rstdiv_hi_late", hi, 32'd0);
    chk("rstdiv_lo_late", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
